load_store_unit: RTL

- Sits between the core's execute/memory stage and the word-organised data memory (30-bit word address, 4-bit byte-lane mask, low-justified write data, full-word read data).
- Accepts one load/store per handshake and decodes funct3.
- Generates the memory word address, lane mask and low-justified store data.
- Extracts and sign/zero-extends load data, flags misaligned or illegal accesses, and returns one registered response per request.

---
 rtl/load_store_unit_pkg.sv | 73 +++++++
 rtl/load_store_unit_if.sv | 41 ++++
 rtl/lsu_lane_align.sv | 33 +++
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared types, funct3 constants and request decode for the
//               load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    localparam int c_funct3_w = 3;
    localparam int c_off_w    = 2;
    localparam int c_mask_w   = 4;

    localparam logic [c_funct3_w-1:0] c_f3_b  = 3'b000;
    localparam logic [c_funct3_w-1:0] c_f3_h  = 3'b001;
    localparam logic [c_funct3_w-1:0] c_f3_w  = 3'b010;
    localparam logic [c_funct3_w-1:0] c_f3_bu = 3'b100;
    localparam logic [c_funct3_w-1:0] c_f3_hu = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    typedef struct packed {
        logic                illegal;     // unsupported funct3 or unsigned store
        logic                misaligned;  // access crosses its natural boundary
        logic [c_mask_w-1:0] mask;        // lane mask for an aligned access
    } lsu_decode_t;

    // Classify a request and build its aligned lane mask.
    function automatic lsu_decode_t lsu_decode(
        input logic                  we,
        input logic [c_funct3_w-1:0] funct3,
        input logic [c_off_w-1:0]    off
    );
        lsu_decode_t d;
        d = '0;
        case (funct3)
            c_f3_b, c_f3_bu: begin
                d.mask = 4'b0001 << off;
            end
            c_f3_h, c_f3_hu: begin
                case (off)
                    2'd0:    d.mask = 4'b0011;
                    2'd1:    d.mask = 4'b0110;
                    2'd2:    d.mask = 4'b1100;
                    default: d.misaligned = 1'b1;
                endcase
            end
            c_f3_w: begin
                if (off == 2'd0) d.mask = 4'b1111;
                else             d.misaligned = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        // Unsigned widths only make sense for loads.
        if (we && funct3[2]) d.illegal = 1'b1;
        return d;
    endfunction

    // Index of the last byte of an access (byte count minus one).
    function automatic logic [1:0] lsu_last_idx(input logic [c_funct3_w-1:0] funct3);
        case (funct3)
            c_f3_h, c_f3_hu: return 2'd1;
            c_f3_w:          return 2'd3;
            default:         return 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Core request/response and data-memory bus of the LSU.
//               master = core + memory side, slave = LSU.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    import load_store_unit_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [c_funct3_w-1:0] req_funct3;
    logic [ADDR_W-1:0]     req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_W-3:0]     mem_address;
    logic [c_mask_w-1:0]   mem_mask;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_read, mem_write, mem_address, mem_mask, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_read, mem_write, mem_address, mem_mask, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Selects the loaded lanes starting at byte offset 'off' and
//               sign- or zero-extends them according to funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [c_funct3_w-1:0] funct3,
    input  logic [c_off_w-1:0]    off,
    input  logic [31:0]           word,
    output logic [31:0]           data
);

    logic [31:0] w_shifted;
    assign w_shifted = word >> {off, 3'b000};

    // Extend the low-justified lanes to 32 bits.
    always_comb begin
        data = w_shifted;
        case (funct3)
            c_f3_b:  data = {{24{w_shifted[7]}},  w_shifted[7:0]};
            c_f3_h:  data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            c_f3_bu: data = {24'h0, w_shifted[7:0]};
            c_f3_hu: data = {16'h0, w_shifted[15:0]};
            default: data = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Three-state LSU (IDLE -> ACCESS -> RESP) between the core and
//               a word-organised data memory. Every request, including an
//               illegal or misaligned one, answers two cycles after accept;
//               rejected requests keep the memory strobes low throughout.
//               Optional macro LSU_BYTE_SPLIT_EN executes misaligned half/word
//               accesses as a sequence of single-byte accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter logic [31:0] RESET_RDATA = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);

    lsu_state_t            r_state;
    logic                  r_ready;
    logic                  r_we;
    logic                  r_err;
    logic [c_funct3_w-1:0] r_funct3;
    logic [c_off_w-1:0]    r_off;
    logic                  r_resp_valid;
    logic [31:0]           r_resp_rdata;
    logic                  r_resp_err;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_W-3:0]     r_mem_address;
    logic [c_mask_w-1:0]   r_mem_mask;
    logic [31:0]           r_mem_wdata;

    lsu_decode_t           w_dec;
    logic                  w_req_err;
    logic                  w_access_done;
    logic [31:0]           w_load_data;
    logic [31:0]           w_resp_data;

    assign w_dec = lsu_decode(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

    lsu_lane_align u_align (
        .funct3 (r_funct3),
        .off    (r_off),
        .word   (bus.mem_rdata),
        .data   (w_load_data)
    );

`ifdef LSU_BYTE_SPLIT_EN
    logic              r_split;
    logic [1:0]        r_cnt;
    logic [1:0]        r_last;
    logic [ADDR_W-1:0] r_byte_addr;
    logic [31:0]       r_acc;
    logic [31:0]       r_wdata;
    logic [7:0]        w_lane_byte;
    logic [31:0]       w_acc_next;
    logic [ADDR_W-1:0] w_next_addr;
    logic [31:0]       w_split_data;

    // Misalignment becomes a byte sequence rather than an error.
    assign w_req_err     = w_dec.illegal;
    assign w_lane_byte   = 8'(bus.mem_rdata >> {r_byte_addr[1:0], 3'b000});
    assign w_acc_next    = r_acc | ({24'h0, w_lane_byte} << {r_cnt, 3'b000});
    assign w_next_addr   = r_byte_addr + ADDR_W'(1);
    assign w_access_done = !r_split || (r_cnt == r_last);
    assign w_resp_data   = r_split ? w_split_data : w_load_data;

    // Accumulated bytes are already low-justified, so align from offset 0.
    lsu_lane_align u_align_split (
        .funct3 (r_funct3),
        .off    (2'b00),
        .word   (w_acc_next),
        .data   (w_split_data)
    );
`else
    assign w_req_err     = w_dec.illegal | w_dec.misaligned;
    assign w_access_done = 1'b1;
    assign w_resp_data   = w_load_data;
`endif

    // Control FSM with every bus output registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ready       <= 1'b0;
            r_we          <= 1'b0;
            r_err         <= 1'b0;
            r_funct3      <= '0;
            r_off         <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_rdata  <= RESET_RDATA;
            r_resp_err    <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_mask    <= '0;
            r_mem_wdata   <= '0;
`ifdef LSU_BYTE_SPLIT_EN
            r_split       <= 1'b0;
            r_cnt         <= '0;
            r_last        <= '0;
            r_byte_addr   <= '0;
            r_acc         <= '0;
            r_wdata       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid && r_ready) begin
                        r_ready  <= 1'b0;
                        r_we     <= bus.req_we;
                        r_err    <= w_req_err;
                        r_funct3 <= bus.req_funct3;
                        r_off    <= bus.req_addr[1:0];
                        r_state  <= ACCESS;
                        if (!w_req_err) begin
                            r_mem_read    <= ~bus.req_we;
                            r_mem_write   <= bus.req_we;
                            r_mem_address <= bus.req_addr[ADDR_W-1:2];
                            r_mem_mask    <= w_dec.mask;
                            r_mem_wdata   <= bus.req_wdata;
                        end
`ifdef LSU_BYTE_SPLIT_EN
                        r_split     <= w_dec.misaligned;
                        r_cnt       <= '0;
                        r_last      <= lsu_last_idx(bus.req_funct3);
                        r_byte_addr <= bus.req_addr;
                        r_acc       <= '0;
                        r_wdata     <= bus.req_wdata;
                        if (w_dec.misaligned && !w_req_err) begin
                            r_mem_mask  <= 4'b0001 << bus.req_addr[1:0];
                            r_mem_wdata <= {24'h0, bus.req_wdata[7:0]};
                        end
`endif
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (w_access_done) begin
                        r_mem_read   <= 1'b0;
                        r_mem_write  <= 1'b0;
                        r_mem_mask   <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= r_err;
                        r_resp_rdata <= (r_err || r_we) ? RESET_RDATA : w_resp_data;
                        r_state      <= RESP;
                    end
`ifdef LSU_BYTE_SPLIT_EN
                    else begin
                        r_cnt         <= r_cnt + 2'd1;
                        r_acc         <= w_acc_next;
                        r_byte_addr   <= w_next_addr;
                        r_mem_address <= w_next_addr[ADDR_W-1:2];
                        r_mem_mask    <= 4'b0001 << w_next_addr[1:0];
                        r_mem_wdata   <= {24'h0, 8'(r_wdata >> {r_cnt + 2'd1, 3'b000})};
                    end
`endif
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_ready      <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_ready;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_rdata  = r_resp_rdata;
    assign bus.resp_err    = r_resp_err;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_mask    = r_mem_mask;
    assign bus.mem_wdata   = r_mem_wdata;

endmodule
`default_nettype wire
